// File: rtl/uart_transmit.sv
// UART serializer with a one-word holding register for back-to-back frames.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_transmit #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int WIDTH            = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             tx_wire_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int P  = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             tx_q, tx_d;
  logic             par_q, par_d;
  logic             cnt_end;
  logic             accept;
  logic             load;
  logic             done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    load        = 1'b0;
    done        = 1'b0;
    tx_d        = 1'b1;
    cnt_end     = (cnt_q == CNT_LAST);
    accept      = valid_in && !hold_full_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_end) begin
          done  = 1'b1;
          cnt_d = '0;
          // Chain straight into the next start bit when a word is waiting.
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (load) begin
      shift_d = hold_q;
      par_d   = ^hold_q;
    end

    hold_full_d = accept | (hold_full_q & ~load);
    hold_d      = accept ? data_in : hold_q;

    // Line value is registered, so it follows the next state.
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      par_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      par_q       <= par_d;
    end
  end

  assign ready_out   = !hold_full_q;
  assign tx_wire_out = tx_q;
  assign busy_out    = (state_q != S_IDLE);
  assign done_out    = done;

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit: frame table, directed corner cases,
// and random traffic against a cycle-indexed frame model.
module tb_uart_transmit;

  localparam int P = 10;
  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FB = W + 3;
`else
  localparam int FB = W + 2;
`endif
  localparam int FL = FB * P;
  localparam int LOGN = 20000;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         ready_out;
  logic         tx_wire_out;
  logic         busy_out;
  logic         done_out;

  uart_transmit #(
    .INPUT_CLOCK_FREQ(100),
    .BAUD_RATE(10),
    .WIDTH(W)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .data_in(data_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .tx_wire_out(tx_wire_out),
    .busy_out(busy_out),
    .done_out(done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  // Model: mt = cycle index inside current frame (-1 idle)
  int           mt = -1;
  logic         mh = 1'b0;
  logic [W-1:0] mw = '0;
  logic         mframe [FB];
  logic         macc;

  logic txlog   [LOGN];
  logic donelog [LOGN];
  int   last_done = -1;
  int   prev_done = -1;

  typedef struct {
    logic [W-1:0] data;
    logic [10:0]  frame;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%b want=%b",
               nm, cyc, act, exp);
    end
  endtask

  task automatic start_frame(input logic [W-1:0] w);
    mframe[0] = 1'b0;
    for (int i = 0; i < W; i++) mframe[1+i] = w[i];
`ifdef UART_TX_PARITY_EN
    mframe[W+1] = ^w;
`endif
    mframe[FB-1] = 1'b1;
    mt = 0;
    mh = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d);
    logic held;
    macc = v && !mh;
    held = mh;
    if (mt >= 0) begin
      if (mt == FL - 1) begin
        if (held) start_frame(mw);
        else mt = -1;
      end else begin
        mt++;
      end
    end else if (held) begin
      start_frame(mw);
    end
    if (macc) begin
      mh = 1'b1;
      mw = d;
    end
  endtask

  task automatic check_outputs();
    logic etx;
    etx = (mt < 0) ? 1'b1 : mframe[mt / P];
    chk("tx", tx_wire_out, etx);
    chk("busy", busy_out, mt >= 0);
    chk("done", done_out, mt == FL - 1);
    chk("ready", ready_out, !mh);
  endtask

  task automatic tick(input logic v, input logic [W-1:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    cyc++;
    model_step(v, d);
    @(negedge clk);
    if (cyc < LOGN) begin
      txlog[cyc]   = tx_wire_out;
      donelog[cyc] = done_out;
    end
    if (done_out) begin
      prev_done = last_done;
      last_done = cyc;
    end
    check_outputs();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mt >= 0 || mh) && n < 500) begin
      tick(1'b0, '0);
      n++;
    end
    if (n >= 500) begin
      nchk++;
      nerr++;
      $display("FAIL idle_timeout cyc=%0d got=busy want=idle", cyc);
    end
  endtask

  task automatic send(input logic [W-1:0] d, output int acc);
    tick(1'b1, d);
    acc = cyc;
    if (!macc) begin
      nchk++;
      nerr++;
      $display("FAIL accept cyc=%0d got=0 want=1", cyc);
    end
  endtask

  initial begin
    int a;
    int d1;
    int nd;
    int n;
    vecs[0].data = 8'hA5;
    vecs[1].data = 8'h07;
    vecs[2].data = 8'h03;
    vecs[3].data = 8'h00;
    vecs[4].data = 8'hFF;
    vecs[5].data = 8'h80;
`ifdef UART_TX_PARITY_EN
    vecs[0].frame = 11'b1_0_10100101_0;
    vecs[1].frame = 11'b1_1_00000111_0;
    vecs[2].frame = 11'b1_0_00000011_0;
    vecs[3].frame = 11'b1_0_00000000_0;
    vecs[4].frame = 11'b1_0_11111111_0;
    vecs[5].frame = 11'b1_1_10000000_0;
`else
    vecs[0].frame = 11'b0_1_10100101_0;
    vecs[1].frame = 11'b0_1_00000111_0;
    vecs[2].frame = 11'b0_1_00000011_0;
    vecs[3].frame = 11'b0_1_00000000_0;
    vecs[4].frame = 11'b0_1_11111111_0;
    vecs[5].frame = 11'b0_1_10000000_0;
`endif

    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;

    // idle after reset
    repeat (50) tick(1'b0, '0);

    // frame table
    foreach (vecs[k]) begin
      wait_idle();
      send(vecs[k].data, a);
      repeat (FL + 3) tick(1'b0, '0);
      for (int b = 0; b < FB; b++) begin
        chk($sformatf("frame%0d_bit%0d", k, b),
            txlog[a + 1 + b * P + P / 2], vecs[k].frame[b]);
      end
      chk("done_at_end", donelog[a + FL], 1'b1);
      nd = 0;
      for (int c = a; c <= a + FL + 3; c++) nd += int'(donelog[c]);
      chk("one_done", nd == 1, 1'b1);
    end

    // back-to-back with changing data while full
    wait_idle();
    send(8'h01, a);
    n = 0;
    do begin
      tick(1'b1, 8'hFF);
      n++;
    end while (!macc && n < 50);
    chk("second_acc", macc, 1'b1);
    n = 0;
    while (mh && n < 300) begin
      tick(1'b1, W'($urandom));
      n++;
    end
    d1 = last_done;
    chk("no_gap", txlog[d1 + 1], 1'b0);
    repeat (FL + 2) tick(1'b0, '0);
    chk("done_spacing", (last_done - prev_done) == FL, 1'b1);

    // accept on the STOP->IDLE edge gives one idle cycle
    wait_idle();
    send(8'h3C, a);
    n = 0;
    while (mt != FL - 1 && n < 300) begin
      tick(1'b0, '0);
      n++;
    end
    d1 = cyc;
    tick(1'b1, 8'hC3);
    tick(1'b0, '0);
    tick(1'b0, '0);
    chk("gap_idle", txlog[d1 + 1], 1'b1);
    chk("gap_start", txlog[d1 + 2], 1'b0);
    wait_idle();

    // asynchronous reset mid-frame
    send(8'h5A, a);
    tick(1'b1, 8'h77);
    while (mt < 34) tick(1'b0, '0);
    valid_in = 1'b0;
    @(posedge clk);
    cyc++;
    model_step(1'b0, '0);
    #2;
    rst_n = 1'b0;
    mt = -1;
    mh = 1'b0;
    #1;
    chk("rst_tx", tx_wire_out, 1'b1);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_ready", ready_out, 1'b1);
    chk("rst_done", done_out, 1'b0);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    repeat (FL + 5) tick(1'b0, '0);
    send(8'hC6, a);
    repeat (FL + 3) tick(1'b0, '0);
    chk("post_rst_done", donelog[a + FL], 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 7) == 0), W'($urandom));
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
